// File: rtl/tpx3_burst_arbiter.sv
// tpx3_burst_arbiter: merges CH_NO first-word-fall-through channel FIFOs into one word
// stream. Round-robin grants, each holding for up to BURST_LEN words, with a per-channel
// enable mask and a running count of transferred words.
module tpx3_burst_arbiter #(
   parameter int CH_NO      = 11,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 16,
   parameter int BL_W       = 5
) (
   input  logic                        BUS_CLK,
   input  logic                        BUS_RST_N,
   input  logic [CH_NO-1:0]            CH_EMPTY,
   input  logic [CH_NO*DATA_WIDTH-1:0] CH_DATA,
   output logic [CH_NO-1:0]            CH_READ,
   input  logic [CH_NO-1:0]            CH_MASK,
   input  logic [BL_W-1:0]             BURST_LEN,
   input  logic                        OUT_READY,
   output logic                        OUT_WRITE,
   output logic [DATA_WIDTH-1:0]       OUT_DATA,
   output logic [4:0]                  GRANT_IDX,
   output logic                        BUSY,
   output logic [31:0]                 WORD_CNT
);

   localparam logic [BL_W-1:0] BL_ONE = {{(BL_W-1){1'b0}}, 1'b1};

   typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

   state_t                state_r, state_s;
   logic [4:0]            ptr_r, ptr_s;
   logic [4:0]            grant_r, grant_s;
   logic [BL_W-1:0]       count_r, count_s;
   logic [31:0]           word_cnt_r;
   logic [BL_W-1:0]       eff_len_s;
   logic [CH_NO-1:0]      req_s;
   logic [CH_NO-1:0]      req_rot_s;
   logic                  any_req_s;
   logic [5:0]            sum_s;
   logic [4:0]            pick_s;
   logic [CH_NO-1:0]      grant_oh_s;
   logic                  g_empty_s;
   logic                  g_mask_s;
   logic [DATA_WIDTH-1:0] g_data_s;
   logic                  xfer_s;
   logic                  last_s;
   logic [4:0]            next_ptr_s;

   assign req_s = ~CH_EMPTY & CH_MASK;

   // Effective burst length: 0 behaves as 1, anything above MAX_BURST is clamped.
   always_comb begin
      if (BURST_LEN == {BL_W{1'b0}}) begin
         eff_len_s = BL_ONE;
      end else if (BURST_LEN > BL_W'(MAX_BURST)) begin
         eff_len_s = BL_W'(MAX_BURST);
      end else begin
         eff_len_s = BURST_LEN;
      end
   end

   // Round-robin search: first requester at or after PTR, wrapping past the last channel.
   always_comb begin
      req_rot_s = CH_NO'({req_s, req_s} >> ptr_r);
      any_req_s = 1'b0;
      sum_s     = 6'd0;
      for (int i = 0; i < CH_NO; i++) begin
         if (req_rot_s[i] && !any_req_s) begin
            any_req_s = 1'b1;
            sum_s     = {1'b0, ptr_r} + 6'(i);
         end else begin
            any_req_s = any_req_s;
         end
      end
      pick_s = (sum_s >= 6'(CH_NO)) ? 5'(sum_s - 6'(CH_NO)) : sum_s[4:0];
   end

   // Granted-channel selection: one-hot decode plus AND-OR mux of status and data.
   always_comb begin
      grant_oh_s = {CH_NO{1'b0}};
      g_empty_s  = 1'b0;
      g_mask_s   = 1'b0;
      g_data_s   = {DATA_WIDTH{1'b0}};
      for (int ch = 0; ch < CH_NO; ch++) begin
         grant_oh_s[ch] = (grant_r == 5'(ch));
         g_empty_s      = g_empty_s | (grant_oh_s[ch] & CH_EMPTY[ch]);
         g_mask_s       = g_mask_s  | (grant_oh_s[ch] & CH_MASK[ch]);
         g_data_s       = g_data_s  | ({DATA_WIDTH{grant_oh_s[ch]}} &
                                       CH_DATA[ch*DATA_WIDTH +: DATA_WIDTH]);
      end
   end

   assign xfer_s     = (state_r == ST_BURST) & OUT_READY & ~g_empty_s & g_mask_s;
   assign last_s     = (count_r == (eff_len_s - BL_ONE));
   assign next_ptr_s = (grant_r == 5'(CH_NO-1)) ? 5'd0 : (grant_r + 5'd1);

   // Next state: arbitrate in IDLE; in BURST count words and leave on last word, empty or mask drop.
   always_comb begin
      state_s = state_r;
      ptr_s   = ptr_r;
      grant_s = grant_r;
      count_s = count_r;
      case (state_r)
         ST_IDLE: begin
            if (any_req_s) begin
               state_s = ST_BURST;
               grant_s = pick_s;
               count_s = {BL_W{1'b0}};
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_BURST: begin
            if (xfer_s) begin
               count_s = count_r + BL_ONE;
               if (last_s) begin
                  state_s = ST_IDLE;
                  ptr_s   = next_ptr_s;
               end else begin
                  state_s = ST_BURST;
               end
            end else if (g_empty_s || !g_mask_s) begin
               state_s = ST_IDLE;
               ptr_s   = next_ptr_s;
            end else begin
               state_s = ST_BURST;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, pointer, grant and burst-count registers.
   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) begin
         state_r <= ST_IDLE;
         ptr_r   <= 5'd0;
         grant_r <= 5'd0;
         count_r <= {BL_W{1'b0}};
      end else begin
         state_r <= state_s;
         ptr_r   <= ptr_s;
         grant_r <= grant_s;
         count_r <= count_s;
      end
   end

   // Total transferred-word counter, wraps naturally at 2^32.
   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) begin
         word_cnt_r <= 32'd0;
      end else if (xfer_s) begin
         word_cnt_r <= word_cnt_r + 32'd1;
      end else begin
         word_cnt_r <= word_cnt_r;
      end
   end

   assign BUSY      = (state_r == ST_BURST);
   assign GRANT_IDX = grant_r;
   assign WORD_CNT  = word_cnt_r;
   assign OUT_WRITE = xfer_s;
   assign CH_READ   = grant_oh_s & {CH_NO{xfer_s}};
   assign OUT_DATA  = BUSY ? g_data_s : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_tpx3_burst_arbiter.sv
// Self-checking bench for tpx3_burst_arbiter: queue-based channel FIFOs, a transaction-level
// arbiter model, directed scenarios with literal expectations, then randomized traffic.
module tb_tpx3_burst_arbiter;
   localparam int N   = 11;
   localparam int DW  = 32;
   localparam int MB  = 16;
   localparam int BLW = 5;

   logic            BUS_CLK = 1'b0;
   logic            BUS_RST_N;
   logic [N-1:0]    CH_EMPTY;
   logic [N*DW-1:0] CH_DATA;
   logic [N-1:0]    CH_READ;
   logic [N-1:0]    CH_MASK;
   logic [BLW-1:0]  BURST_LEN;
   logic            OUT_READY;
   logic            OUT_WRITE;
   logic [DW-1:0]   OUT_DATA;
   logic [4:0]      GRANT_IDX;
   logic            BUSY;
   logic [31:0]     WORD_CNT;

   int checks   = 0;
   int failures = 0;

   logic [31:0] fifo_q [N][$];
   int          seq_no [N];

   // Model state: whether a grant is active, its channel, words so far, search pointer.
   bit          m_busy;
   int          m_ptr, m_g, m_count, m_words;
   logic [31:0] m_cnt;
   string       grant_log, len_log;
   bit          did_mid_reset;

   tpx3_burst_arbiter #(.CH_NO(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .BL_W(BLW)) dut (
      .BUS_CLK(BUS_CLK), .BUS_RST_N(BUS_RST_N), .CH_EMPTY(CH_EMPTY), .CH_DATA(CH_DATA),
      .CH_READ(CH_READ), .CH_MASK(CH_MASK), .BURST_LEN(BURST_LEN), .OUT_READY(OUT_READY),
      .OUT_WRITE(OUT_WRITE), .OUT_DATA(OUT_DATA), .GRANT_IDX(GRANT_IDX), .BUSY(BUSY),
      .WORD_CNT(WORD_CNT)
   );

   // Free-running bus clock.
   always #5 BUS_CLK = ~BUS_CLK;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_str(input string nm, input string act, input string exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=\"%s\" required=\"%s\"", nm, act, exp);
      end
   endtask

   task automatic push(input int ch, input int n);
      for (int k = 0; k < n; k++) begin
         fifo_q[ch].push_back({ch[7:0], seq_no[ch][23:0]});
         seq_no[ch]++;
      end
   endtask

   task automatic drive_fifos();
      for (int ch = 0; ch < N; ch++) begin
         CH_EMPTY[ch] = (fifo_q[ch].size() == 0);
         CH_DATA[ch*DW +: DW] = (fifo_q[ch].size() != 0) ? fifo_q[ch][0] : 32'd0;
      end
   endtask

   function automatic int eff_len(input int bl);
      if (bl < 1) return 1;
      if (bl > MB) return MB;
      return bl;
   endfunction

   task automatic model_reset();
      m_busy  = 1'b0;
      m_ptr   = 0;
      m_g     = 0;
      m_count = 0;
      m_words = 0;
      m_cnt   = 32'd0;
   endtask

   task automatic end_burst();
      m_busy  = 1'b0;
      m_ptr   = (m_g + 1) % N;
      len_log = {len_log, $sformatf("%0d,", m_words)};
   endtask

   // One clock: called at a negedge with inputs set; checks outputs, then advances the model.
   task automatic step();
      bit               xfer;
      logic [N-1:0]     e_read;
      logic [DW-1:0]    e_data;
      drive_fifos();
      #1;
      xfer   = 1'b0;
      e_read = '0;
      e_data = 32'd0;
      if (m_busy) begin
         xfer = OUT_READY && (fifo_q[m_g].size() != 0) && CH_MASK[m_g];
         if (xfer) e_read[m_g] = 1'b1;
         e_data = CH_DATA[m_g*DW +: DW];
      end
      chk("ch_read",   64'(CH_READ),   64'(e_read));
      chk("out_write", 64'(OUT_WRITE), 64'(xfer));
      chk("out_data",  64'(OUT_DATA),  64'(e_data));
      chk("busy",      64'(BUSY),      64'(m_busy));
      chk("grant_idx", 64'(GRANT_IDX), 64'(m_g));
      chk("word_cnt",  64'(WORD_CNT),  64'(m_cnt));
      @(posedge BUS_CLK);
      if (m_busy) begin
         if (xfer) begin
            void'(fifo_q[m_g].pop_front());
            m_cnt = m_cnt + 32'd1;
            m_words++;
            if (m_count == eff_len(int'(BURST_LEN)) - 1) end_burst();
            else m_count++;
         end else if (fifo_q[m_g].size() == 0 || !CH_MASK[m_g]) begin
            end_burst();
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            int c;
            c = (m_ptr + i) % N;
            if (fifo_q[c].size() != 0 && CH_MASK[c]) begin
               m_busy    = 1'b1;
               m_g       = c;
               m_count   = 0;
               m_words   = 0;
               grant_log = {grant_log, $sformatf("%0d,", c)};
               break;
            end
         end
      end
      @(negedge BUS_CLK);
   endtask

   // Asynchronous reset asserted at a negedge; outputs must clear without waiting for a clock edge.
   task automatic do_reset();
      drive_fifos();
      BUS_RST_N = 1'b0;
      #1;
      chk("rst_ch_read",   64'(CH_READ),   64'd0);
      chk("rst_out_write", 64'(OUT_WRITE), 64'd0);
      chk("rst_word_cnt",  64'(WORD_CNT),  64'd0);
      chk("rst_grant_idx", 64'(GRANT_IDX), 64'd0);
      chk("rst_busy",      64'(BUSY),      64'd0);
      chk("rst_out_data",  64'(OUT_DATA),  64'd0);
      model_reset();
      @(negedge BUS_CLK);
      BUS_RST_N = 1'b1;
   endtask

   function automatic bit pending();
      if (m_busy) return 1'b1;
      for (int ch = 0; ch < N; ch++) if (fifo_q[ch].size() != 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drain(input string nm, input int max_cyc);
      int n;
      n = 0;
      while (pending() && n < max_cyc) begin
         step();
         n++;
      end
      chk({nm, "_drained"}, 64'(n < max_cyc), 64'd1);
   endtask

   task automatic clear_logs();
      grant_log = "";
      len_log   = "";
   endtask

   initial begin
      int n;
      BUS_RST_N = 1'b0;
      CH_MASK   = {N{1'b1}};
      BURST_LEN = 5'd4;
      OUT_READY = 1'b1;
      CH_DATA   = '0;
      CH_EMPTY  = {N{1'b1}};
      model_reset();
      clear_logs();
      did_mid_reset = 1'b0;

      // Reset with traffic present, then ch3 with 10 words and BURST_LEN=4.
      push(3, 10);
      @(negedge BUS_CLK);
      do_reset();
      drain("t2", 200);
      chk_str("t2_grants", grant_log, "3,3,3,");
      chk_str("t2_bursts", len_log, "4,4,2,");
      chk("t2_word_cnt", 64'(WORD_CNT), 64'd10);

      // Three full channels, BURST_LEN=2: strict round robin two words each.
      do_reset();
      clear_logs();
      BURST_LEN = 5'd2;
      push(0, 4); push(1, 4); push(2, 4);
      drain("t3", 200);
      chk_str("t3_grants", grant_log, "0,1,2,0,1,2,");
      chk_str("t3_bursts", len_log, "2,2,2,2,2,2,");

      // Ready toggling 1,0,0: pops only on ready cycles, one burst of 8.
      clear_logs();
      BURST_LEN = 5'd8;
      push(5, 8);
      n = 0;
      while (pending() && n < 200) begin
         OUT_READY = (n % 3 == 0);
         step();
         n++;
      end
      chk("t4_drained", 64'(n < 200), 64'd1);
      OUT_READY = 1'b1;
      chk_str("t4_bursts", len_log, "8,");
      chk("t4_word_cnt", 64'(WORD_CNT), 64'd20);

      // Mask drop on the granted channel after two words aborts the burst.
      do_reset();
      clear_logs();
      push(6, 6); push(7, 6);
      n = 0;
      while (!(m_busy && m_g == 6 && m_words == 2) && n < 50) begin
         step();
         n++;
      end
      chk("t5_reached", 64'(n < 50), 64'd1);
      CH_MASK[6] = 1'b0;
      step();
      chk("t5_idle_after_drop", 64'(BUSY), 64'd0);
      CH_MASK[6] = 1'b1;
      drain("t5", 200);
      chk_str("t5_grants", grant_log, "6,7,6,");
      chk_str("t5_bursts", len_log, "2,6,4,");

      // BURST_LEN=0 gives single-word grants; 31 clamps to 16.
      clear_logs();
      BURST_LEN = 5'd0;
      push(1, 3);
      drain("t6a", 100);
      chk_str("t6a_bursts", len_log, "1,1,1,");
      clear_logs();
      BURST_LEN = 5'd31;
      push(2, 20);
      drain("t6b", 100);
      chk_str("t6b_bursts", len_log, "16,4,");

      // Word counter wrap from a preset near the top.
      dut.word_cnt_r = 32'hFFFF_FFFE;
      m_cnt = 32'hFFFF_FFFE;
      BURST_LEN = 5'd4;
      push(4, 3);
      drain("t6c", 100);
      chk("t6c_wrap", 64'(WORD_CNT), 64'd1);

      // Randomized traffic, masks, ready and burst length, with one mid-burst reset.
      for (int k = 0; k < 3000; k++) begin
         for (int ch = 0; ch < N; ch++) begin
            if ($urandom_range(0, 3) == 0 && fifo_q[ch].size() < 8) push(ch, $urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) CH_MASK[ch] = ~CH_MASK[ch];
         end
         OUT_READY = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 31) == 0) BURST_LEN = 5'($urandom_range(0, 31));
         if (k >= 1500 && !did_mid_reset && m_busy && OUT_READY) begin
            did_mid_reset = 1'b1;
            do_reset();
         end else begin
            step();
         end
      end
      chk("rand_mid_reset_done", 64'(did_mid_reset), 64'd1);
      CH_MASK   = {N{1'b1}};
      OUT_READY = 1'b1;
      drain("rand", 2000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
